// File: rtl/waveform_packer_pkg.sv
// waveform_packer_pkg
//   Shared definitions for the waveform sample packer:
//   - default decimation depth and sample width
//   - packer state encoding (S_IDLE / S_ACCUM)
//   - accumulator width constant and helper
package waveform_packer_pkg;

  localparam int LOG2_DECIM_MAX_DEF = 8;
  localparam int SAMPLE_WIDTH_DEF   = 32;

  // A window sums at most 2^LOG2_DECIM_MAX samples, so this many extra
  // bits above the sample width make overflow impossible.
  localparam int ACC_WIDTH_DEF = SAMPLE_WIDTH_DEF + LOG2_DECIM_MAX_DEF;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } packer_state_e;

  function automatic int accWidth(input int sampleWidth, input int log2DecimMax);
    return sampleWidth + log2DecimMax;
  endfunction

endpackage

// File: rtl/packer_lane_accum.sv
// packer_lane_accum
//   One sample lane of the packer. With WAVEFORM_PACKER_AVG_EN defined it
//   accumulates the window and emits floor(sum / 2^kEff); otherwise it
//   holds window sample 0 (pure decimation).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        discard the open window (enable low)
//   sampleEn     a sample is taken this cycle
//   first        this sample is window sample 0
//   last         this sample closes the window
//   kEff         effective decimation exponent for this window
//   sample       lane sample (signed)
//   laneOut      registered lane result, updated on window close
module packer_lane_accum
  import waveform_packer_pkg::*;
#(
  parameter int SAMPLE_WIDTH   = SAMPLE_WIDTH_DEF,
  parameter int LOG2_DECIM_MAX = LOG2_DECIM_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    sampleEn,
  input  logic                    first,
  input  logic                    last,
  input  logic [3:0]              kEff,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  output logic [SAMPLE_WIDTH-1:0] laneOut
);

`ifdef WAVEFORM_PACKER_AVG_EN
  localparam int ACC_W = accWidth(SAMPLE_WIDTH, LOG2_DECIM_MAX);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;

  // Sample 0 starts a fresh sum regardless of what the register holds.
  always_comb begin
    sum     = (first ? '0 : acc) + {{LOG2_DECIM_MAX{sample[SAMPLE_WIDTH-1]}}, sample};
    shifted = sum >>> kEff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      laneOut <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (sampleEn) begin
      if (last) begin
        laneOut <= shifted[SAMPLE_WIDTH-1:0];
        acc     <= '0;
      end else begin
        acc <= sum;
      end
    end
  end
`else
  localparam int unusedDepth = LOG2_DECIM_MAX;
  logic unusedK;
  logic [SAMPLE_WIDTH-1:0] hold;

  assign unusedK = ^kEff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold    <= '0;
      laneOut <= '0;
    end else if (clear) begin
      hold <= '0;
    end else if (sampleEn) begin
      if (first) hold <= sample;
      // A one-sample window closes on sample 0 itself.
      if (last) laneOut <= first ? sample : hold;
    end
  end
`endif

endmodule

// File: rtl/waveform_sample_packer.sv
// waveform_sample_packer
//   Decimates NUM_CHANNELS parallel signed sample lanes by 2^kEff and packs
//   them into one word for the waveform recorder, with window-aligned
//   trigger pulses.
//   Optional feature macro: WAVEFORM_PACKER_AVG_EN (window averaging);
//   undefined = output window sample 0.
// Handshake: sampleValid qualifies sampleData, one sample per high cycle,
//   no backpressure. valid is a one-cycle pulse one cycle after the sample
//   that closes a window; data and triggers are stable while valid is high
//   and triggers is 0 otherwise.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   enable          packing enable; low discards the open window
//   log2Decim       requested decimation exponent (clamped to LOG2_DECIM_MAX)
//   sampleData      lane samples, lane n at [n*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   sampleValid     sample qualifier
//   triggersIn      raw level triggers
//   data/valid      packed decimated output word and its qualifier
//   triggers        OR of triggersIn over the closed window
module waveform_sample_packer
  import waveform_packer_pkg::*;
#(
  parameter int  NUM_CHANNELS   = 4,
  parameter int  SAMPLE_WIDTH   = SAMPLE_WIDTH_DEF,
  parameter int  LOG2_DECIM_MAX = LOG2_DECIM_MAX_DEF,
  localparam int DATA_WIDTH     = NUM_CHANNELS * SAMPLE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [3:0]            log2Decim,
  input  logic [DATA_WIDTH-1:0] sampleData,
  input  logic                  sampleValid,
  input  logic [7:0]            triggersIn,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic [7:0]            triggers
);

  localparam logic [LOG2_DECIM_MAX:0] CNT_ONE = (LOG2_DECIM_MAX+1)'(1);

  packer_state_e state;
  packer_state_e stateNext;

  logic [LOG2_DECIM_MAX-1:0] cnt;
  logic [3:0]                kReg;
  logic [3:0]                kIn;
  logic [3:0]                kCur;
  logic [LOG2_DECIM_MAX:0]   winLast;
  logic                      take;
  logic                      first;
  logic                      close;
  logic [7:0]                trigLatch;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE:  if (enable)  stateNext = S_ACCUM;
      S_ACCUM: if (!enable) stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  // Window control. The sample taken together with enable's rising edge
  // already counts, so gating uses enable directly rather than the state.
  // kEff is latched on sample 0; on that sample itself the fresh request
  // is used since kReg has not been written yet.
  always_comb begin
    take    = enable & sampleValid;
    first   = (cnt == '0);
    kIn     = (int'(log2Decim) > LOG2_DECIM_MAX) ? 4'(LOG2_DECIM_MAX) : log2Decim;
    kCur    = first ? kIn : kReg;
    winLast = (CNT_ONE << kCur) - CNT_ONE;
    close   = take & ({1'b0, cnt} == winLast);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      kReg      <= '0;
      trigLatch <= '0;
      valid     <= 1'b0;
      triggers  <= '0;
    end else begin
      valid    <= close;
      triggers <= close ? (trigLatch | triggersIn) : 8'h00;
      if (!enable) begin
        cnt       <= '0;
        trigLatch <= '0;
      end else begin
        // Triggers are collected every enabled cycle, sample or not.
        trigLatch <= close ? 8'h00 : (trigLatch | triggersIn);
        if (take) begin
          if (first) kReg <= kIn;
          cnt <= close ? '0 : cnt + 1'b1;
        end
      end
    end
  end

  for (genvar n = 0; n < NUM_CHANNELS; n++) begin : gLane
    packer_lane_accum #(
      .SAMPLE_WIDTH  (SAMPLE_WIDTH),
      .LOG2_DECIM_MAX(LOG2_DECIM_MAX)
    ) uLane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (~enable),
      .sampleEn(take),
      .first   (first),
      .last    (close),
      .kEff    (kCur),
      .sample  (sampleData[n*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
      .laneOut (data[n*SAMPLE_WIDTH +: SAMPLE_WIDTH])
    );
  end

endmodule
